// File: rtl/imm_pack_if.sv
// Stream interface for imm_pack: operand input side and packed-word output side.
interface imm_pack_if #(
  parameter int IN_W  = 16,
  parameter int NIB_W = 4,
  parameter int LANES = 4
);
  localparam int OUT_W = NIB_W * LANES;
  localparam int CNT_W = $clog2(LANES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              sat_en;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic [LANES-1:0]  out_ovf;

  modport master (
    output in_valid, in_data, sat_en, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, sat_en, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: narrows 16-bit signed operands to 4-bit fields and packs four of
// them (lane0 in the low nibble) into one word, flagging out-of-range operands.
//
// state | meaning
// FILL  | accepting operands into lanes, in_ready high
// HOLD  | packed word presented, waiting for out_ready
module imm_pack #(
  parameter int IN_W  = 16,
  parameter int NIB_W = 4,
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  imm_pack_if.slave  bus
);
  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = $clog2(LANES + 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [LANES-1:0][NIB_W-1:0] lane_q;
  logic [LANES-1:0]            ovf_q;
  logic [CNT_W-1:0]            lane_cnt;
  logic [IDX_W-1:0]            lane_idx;
  logic [IN_W-NIB_W:0]         top_bits;
  logic                        fits;
  logic                        accept;
  logic                        last_lane;
  logic [NIB_W-1:0]            field;

  // An operand fits when every bit from the field sign bit upward agrees.
  assign top_bits  = bus.in_data[IN_W-1:NIB_W-1];
  assign fits      = (&top_bits) | ~(|top_bits);
  assign accept    = bus.in_valid && (state_q == FILL);
  assign lane_idx  = lane_cnt[IDX_W-1:0];
  assign last_lane = (lane_cnt == CNT_W'(LANES - 1));

  // Narrow the incoming operand: truncate, or clamp to the field extremes.
  always_comb begin
    field = bus.in_data[NIB_W-1:0];
    if (!fits && bus.sat_en) begin
      field = bus.in_data[IN_W-1] ? {1'b1, {(NIB_W-1){1'b0}}}
                                  : {1'b0, {(NIB_W-1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= FILL;
    else         state_q <= state_d;
  end

  // Next state: close the word when full, or on flush if anything is in it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept && last_lane)                          state_d = HOLD;
        else if (bus.flush && (accept || lane_cnt != '0)) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Lane storage; lane_cnt doubles as the valid-lane count while holding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q   <= '0;
      ovf_q    <= '0;
      lane_cnt <= '0;
    end else if (accept) begin
      lane_q[lane_idx] <= field;
      ovf_q[lane_idx]  <= ~fits;
      lane_cnt         <= lane_cnt + CNT_W'(1);
    end else if (state_q == HOLD && bus.out_ready) begin
      lane_q   <= '0;
      ovf_q    <= '0;
      lane_cnt <= '0;
    end
  end

  // Outputs: word fields are only visible while holding, zero otherwise.
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == HOLD);
    bus.out_data  = '0;
    bus.out_count = '0;
    bus.out_ovf   = '0;
    if (state_q == HOLD) begin
      bus.out_data  = lane_q;
      bus.out_count = lane_cnt;
      bus.out_ovf   = ovf_q;
    end
  end
endmodule

// File: tb/tb_imm_pack.sv
// Testbench for imm_pack: queue-based reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_imm_pack;
  logic clk    = 1'b0;
  logic resetn = 1'b0;

  imm_pack_if bus ();

  imm_pack dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operands collect in a queue; a word forms when four are
  // present, or when flush arrives with at least one present.
  logic [3:0]  m_fld[$];
  bit          m_ovf[$];
  bit          m_hold  = 1'b0;
  logic [15:0] m_data  = '0;
  int          m_cnt   = 0;
  logic [3:0]  m_ovfw  = '0;
  logic [4:0]  m_r;

  function automatic logic [4:0] narrow(logic [15:0] d, logic sat);
    int v;
    v = $signed(d);
    if (v >= -8 && v <= 7) return {1'b0, d[3:0]};
    if (sat)               return {1'b1, (v < 0) ? 4'h8 : 4'h7};
    return {1'b1, d[3:0]};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_hold = 1'b0;
      m_fld.delete();
      m_ovf.delete();
      m_data = '0;
      m_cnt  = 0;
      m_ovfw = '0;
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_hold = 1'b0;
        m_data = '0;
        m_cnt  = 0;
        m_ovfw = '0;
      end
    end else begin
      if (bus.in_valid) begin
        m_r = narrow(bus.in_data, bus.sat_en);
        m_fld.push_back(m_r[3:0]);
        m_ovf.push_back(m_r[4]);
      end
      if (m_fld.size() == 4 || (bus.flush && m_fld.size() > 0)) begin
        m_hold = 1'b1;
        m_cnt  = m_fld.size();
        m_data = '0;
        m_ovfw = '0;
        for (int i = 0; i < m_cnt; i++) begin
          m_data = m_data | ({12'h000, m_fld[i]} << (4 * i));
          m_ovfw[i] = m_ovf[i];
        end
        m_fld.delete();
        m_ovf.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, !m_hold});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_hold});
    chk("out_data",  {16'b0, bus.out_data},  {16'b0, m_data});
    chk("out_count", {29'b0, bus.out_count}, m_cnt);
    chk("out_ovf",   {28'b0, bus.out_ovf},   {28'b0, m_ovfw});
  end

  task automatic send(logic [15:0] d, logic sat, logic fl);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sat_en   = sat;
    bus.flush    = fl;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("accept_wait", {31'b0, acc}, 32'd1);
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_word(string name, output int waited);
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic expect_word(string name, logic [15:0] d, int c, logic [3:0] o,
                             output int waited);
    wait_word(name, waited);
    chk({name, "_data"},  {16'b0, bus.out_data},  {16'b0, d});
    chk({name, "_count"}, {29'b0, bus.out_count}, c);
    chk({name, "_ovf"},   {28'b0, bus.out_ovf},   {28'b0, o});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] ops[$];
    logic [15:0] d;
    logic [3:0]  lane;
    logic [15:0] se;
    int v;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sat_en    = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  {16'b0, bus.out_data},  32'd0);
    chk("rst_out_count", {29'b0, bus.out_count}, 32'd0);
    chk("rst_out_ovf",   {28'b0, bus.out_ovf},   32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // In-range operands, word one cycle after the 4th accept.
    send(16'h0003, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFF8, 1'b1, 1'b0);
    send(16'h0007, 1'b1, 1'b0);
    expect_word("t1", 16'h78F3, 4, 4'b0000, w);
    chk("t1_latency", w, 32'd0);

    // Out-of-range operands, saturating then truncating.
    send(16'h0008, 1'b1, 1'b0);
    send(16'hFFF7, 1'b1, 1'b0);
    send(16'h7FFF, 1'b1, 1'b0);
    send(16'h8000, 1'b1, 1'b0);
    expect_word("t2_sat", 16'h8787, 4, 4'b1111, w);
    send(16'h0008, 1'b0, 1'b0);
    send(16'hFFF7, 1'b0, 1'b0);
    send(16'h7FFF, 1'b0, 1'b0);
    send(16'h8000, 1'b0, 1'b0);
    expect_word("t2_trunc", 16'h0F78, 4, 4'b1111, w);

    // Partial words through flush.
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b1, 1'b0);
    flush_pulse();
    expect_word("t3_flush", 16'h0021, 2, 4'b0000, w);
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b1, 1'b0);
    send(16'h0003, 1'b1, 1'b1);
    expect_word("t3_coinc", 16'h0321, 3, 4'b0000, w);
    @(posedge clk);
    #1;
    flush_pulse();
    for (int k = 0; k < 3; k++) begin
      chk("t3_empty_flush", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Back-pressure: held word stable, input ignored.
    bus.out_ready = 1'b0;
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b1, 1'b0);
    send(16'h0003, 1'b1, 1'b0);
    send(16'h0004, 1'b1, 1'b0);
    expect_word("t4", 16'h4321, 4, 4'b0000, w);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0005 + 16'(k);
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("t4_hold_data",  {16'b0, bus.out_data},  32'h4321);
      chk("t4_hold_count", {29'b0, bus.out_count}, 32'd4);
      chk("t4_hold_ready", {31'b0, bus.in_ready},  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_release_ready", {31'b0, bus.in_ready},  32'd1);
    chk("t4_release_valid", {31'b0, bus.out_valid}, 32'd0);

    // Reset after three accepts discards them.
    send(16'h0007, 1'b1, 1'b0);
    send(16'h0006, 1'b1, 1'b0);
    send(16'h0005, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_ready", {31'b0, bus.in_ready},  32'd1);
    chk("t5_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_rst_data",  {16'b0, bus.out_data},  32'd0);
    chk("t5_rst_count", {29'b0, bus.out_count}, 32'd0);
    chk("t5_rst_ovf",   {28'b0, bus.out_ovf},   32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0001, 1'b1, 1'b0);
    send(16'hFFFE, 1'b1, 1'b0);
    send(16'h0000, 1'b1, 1'b0);
    send(16'h0005, 1'b1, 1'b0);
    expect_word("t5_after", 16'h50E1, 4, 4'b0000, w);

    // Random in-range round trip through sign extension.
    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(0, 15)) - 8;
      d = 16'(v);
      ops.push_back(d);
      send(d, 1'($urandom_range(0, 1)), 1'b0);
      if ((n % 4) == 3) begin
        wait_word("t6", w);
        chk("t6_ovf",   {28'b0, bus.out_ovf},   32'd0);
        chk("t6_count", {29'b0, bus.out_count}, 32'd4);
        for (int l = 0; l < 4; l++) begin
          lane = bus.out_data[4*l +: 4];
          se   = {{12{lane[3]}}, lane};
          chk("t6_roundtrip", {16'b0, se}, {16'b0, ops.pop_front()});
        end
      end
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
